// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the load/store path to the unified word memory:
//   access-size encodings, the memory access FSM state type, and the lane
//   select / extend / merge helpers.  The helpers are pure functions so that
//   the writeback stage can reuse the same lane rules as mem_access_unit.
//   No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } mem_state_e;

    // Pull the addressed lane out of a memory word (little-endian) and
    // sign- or zero-extend it.  Word accesses pass the word through untouched.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input mem_size_e   size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
            SIZE_HALF: r = {{16{sgn & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the right-aligned store
    // data; all other lanes are carried over bit for bit.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input mem_size_e   size,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = old_word;
        case (size)
            SIZE_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default:   r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//   Combinational lane logic for one memory access.
//   Ports:
//     size     in  access size (mem_size_e)
//     sgn      in  1 = sign-extend loads
//     off      in  byte offset within the word (addr[1:0])
//     rd_word  in  word read from memory
//     wdata    in  right-aligned store data
//     ld_data  out extracted + extended load result
//     st_word  out rd_word with the addressed lane replaced by wdata
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    assign ld_data = lane_extract(rd_word, size, off, sgn);
    assign st_word = lane_merge(rd_word, wdata, size, off);

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Initiator between the core's load/store datapath and the single-port word
//   memory (registered word write, combinational read).  Handles byte/half/word
//   loads with extension and sub-word stores via read-modify-write.  Illegal
//   size, misaligned and out-of-range requests complete with err=1 without
//   touching memory.
//   Ports:
//     clk, rst          clock; synchronous active-low reset
//     req/req_*         request valid, direction, size, signedness, address, data
//     busy              high whenever the FSM is not IDLE
//     done, err, rdata  completion pulse, reject flag, load result
//     mem_addr/wdata/we memory write/address side; mem_rdata read data
//     dbg_state         current FSM state, for observation only
//
//   Handshake: req is the valid, ~busy is the ready.  A request is taken on a
//   rising edge where req=1 and the unit is IDLE; the core keeps req and its
//   payload stable until it sees done, and any req seen while busy is ignored.
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // 33 bits so a full 4 GiB memory would not wrap the limit to zero.
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    mem_state_e  state_q, state_d;
    logic        we_q, we_d;
    mem_size_e   size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;

    mem_size_e   req_size_e;
    logic        req_bad;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign req_size_e = mem_size_e'(req_size);

    // First-match order is irrelevant for the outcome: any hit rejects.
    assign req_bad = (req_size_e == SIZE_ILL)
                  || ((req_size_e == SIZE_HALF) && req_addr[0])
                  || ((req_size_e == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                  || ({1'b0, req_addr} >= MEM_BYTES);

    mem_lane_align u_align (
        .size    (size_q),
        .sgn     (sgn_q),
        .off     (addr_q[1:0]),
        .rd_word (mem_rdata),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = req_we;
                    size_d  = req_size_e;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = ST_DONE;
                    end else if (req_we && (req_size_e == SIZE_WORD)) begin
                        // Full-word store needs no old data: write directly.
                        mem_wdata_d = req_wdata;
                        state_d     = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    // Sub-word store: old word is merged straight into the
                    // write-data register, so it is the RD capture itself.
                    mem_wdata_d = st_word;
                    state_d     = ST_WR;
                end else begin
                    rdata_d = ld_data;
                    state_d = ST_DONE;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        mem_we_d = (state_d == ST_WR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SIZE_BYTE;
            sgn_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;
    // Gated by reset so a reset landing in the WR cycle cannot commit a write.
    assign mem_we    = mem_we_q & rst;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Bench for mem_access_unit: 1024x32 async-read memory (cleared while rst=0),
//   a directed vector table, back-to-back and reset-abort sequences, and a
//   randomized regression against a byte-level reference memory.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory the DUT talks to ----------------
    logic [31:0] tb_mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;

    assign mem_rdata = tb_mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'h0;
        end else if (mem_we) begin
            tb_mem[mem_addr[11:2]] <= mem_wdata;
        end else if (bd_we) begin
            tb_mem[bd_idx] <= bd_data;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:1023];

    function automatic void ref_clear();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    endfunction

    function automatic void model_op(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output logic [31:0] e_rdata,
        output logic        e_err,
        output int          e_lat,
        output int          e_wes
    );
        int unsigned idx, sh;
        logic [31:0] w, v, mask;
        e_rdata = 32'h0;
        e_wes   = 0;
        e_lat   = 1;
        e_err   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0)
               || (size == 2'd2 && (addr % 4) != 0) || (addr >= 32'd4096);
        if (e_err) return;
        idx = addr / 4;
        sh  = (addr % 4) * 8;
        w   = ref_mem[idx];
        if (!we) begin
            e_lat = 2;
            if (size == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (sgn && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2'd1) begin
                v = (w >> sh) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = w;
            end
            e_rdata = v;
        end else begin
            e_wes = 1;
            if (size == 2'd2) begin
                ref_mem[idx] = wdata;
                e_lat = 2;
            end else begin
                mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
                e_lat = 3;
            end
        end
    endfunction

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Caller is at a negedge with the DUT IDLE.  Returns at the negedge of the
    // IDLE cycle that follows DONE.
    task automatic do_op(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  bit          hold,
        output logic [31:0] o_rdata,
        output logic        o_err,
        output int          o_lat,
        output int          o_wes,
        output logic [31:0] o_wdat,
        output bit          o_addr_bad,
        output bit          o_busy_bad,
        output bit          o_idle_bad
    );
        req        = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        o_rdata    = 32'hX;
        o_err      = 1'bX;
        o_lat      = 0;
        o_wes      = 0;
        o_wdat     = 32'h0;
        o_addr_bad = 1'b0;
        o_busy_bad = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (!hold) req = 1'b0;
            if (mem_we) begin
                o_wes++;
                o_wdat = mem_wdata;
            end
            if (mem_addr !== {addr[31:2], 2'b00}) o_addr_bad = 1'b1;
            if (busy !== 1'b1) o_busy_bad = 1'b1;
            if (done === 1'b1) begin
                o_lat   = n;
                o_rdata = rdata;
                o_err   = err;
                break;
            end
        end
        @(negedge clk);
        if (mem_we) o_wes++;
        o_idle_bad = (busy !== 1'b0) || (done !== 1'b0) || (rdata !== o_rdata);
    endtask

    task automatic backdoor(input int idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = 10'(idx);
        bd_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Runs one op through DUT and model, compares everything observable.
    task automatic run_checked(input string tag, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit hold);
        logic [31:0] a_rd, a_wd, e_rd;
        logic        a_err, e_err;
        int          a_lat, a_wes, e_lat, e_wes;
        bit          ab, bb, ib;
        model_op(we, size, sgn, addr, wdata, e_rd, e_err, e_lat, e_wes);
        do_op(we, size, sgn, addr, wdata, hold, a_rd, a_err, a_lat, a_wes, a_wd, ab, bb, ib);
        chk({tag, " latency"}, a_lat, e_lat);
        chk({tag, " err"}, {31'b0, a_err}, {31'b0, e_err});
        chk({tag, " rdata"}, a_rd, e_rd);
        chk({tag, " mem_we pulses"}, a_wes, e_wes);
        chk({tag, " protocol"}, {29'b0, ab, bb, ib}, 32'h0);
        if (!e_err) chk({tag, " mem word"}, tb_mem[addr[11:2]], ref_mem[addr[11:2]]);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          pre;
        logic [31:0] pre_data;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
        int          chk_idx;
        logic [31:0] exp_word;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin
        logic [31:0] a_rd, a_wd;
        logic        a_err;
        int          a_lat, a_wes;
        bit          ab, bb, ib;
        string       t;

        //         pre  pre_data      we    size  sgn   addr          wdata         rdata         err   lat wes idx word
        vecs[0]  = '{1, 32'h8899AABB, 1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFFFF99, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[1]  = '{0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,        32'h00008899, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[2]  = '{0, 32'h0,        1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[3]  = '{0, 32'h0,        1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,        32'h00000088, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[4]  = '{0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFFFFBB, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[5]  = '{0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[6]  = '{0, 32'h0,        1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[7]  = '{0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 4,    32'h8899AABB};
        vecs[8]  = '{1, 32'h11223344, 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h123456EE, 32'h0,        1'b0, 3, 1, 4,    32'h1122EE44};
        vecs[9]  = '{1, 32'h11223344, 1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'hCAFEBEEF, 32'h0,        1'b0, 3, 1, 4,    32'hBEEF3344};
        vecs[10] = '{0, 32'h0,        1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'h00000077, 32'h0,        1'b0, 3, 1, 4,    32'hBEEF3377};
        vecs[11] = '{0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 4,    32'hDEADBEEF};
        vecs[12] = '{0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h0000_000F, 32'h00000001, 32'h0,        1'b1, 1, 0, 3,    32'h0};
        vecs[13] = '{0, 32'h0,        1'b1, 2'd1, 1'b0, 32'h0000_0013, 32'h0000FFFF, 32'h0,        1'b1, 1, 0, 4,    32'hDEADBEEF};
        vecs[14] = '{0, 32'h0,        1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'h00000000, 32'h0,        1'b1, 1, 0, 4,    32'hDEADBEEF};
        vecs[15] = '{0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'h12345678, 32'h0,        1'b1, 1, 0, 0,    32'h0};
        vecs[16] = '{0, 32'h0,        1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 4,    32'hDEADBEEF};
        vecs[17] = '{0, 32'h0,        1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0,        32'h0,        1'b1, 1, 0, 4,    32'hDEADBEEF};
        vecs[18] = '{0, 32'h0,        1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'hA5A5A5A5, 32'h0,        1'b0, 2, 1, 1023, 32'hA5A5A5A5};
        vecs[19] = '{0, 32'h0,        1'b0, 2'd0, 1'b1, 32'h0000_0FFF, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 0, 1023, 32'hA5A5A5A5};
        vecs[20] = '{0, 32'h0,        1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,        32'h0,        1'b1, 1, 0, 0,    32'h0};
        vecs[21] = '{0, 32'h0,        1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1, 0, 0,    32'h0};

        rst = 1'b0; req = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; bd_we = 1'b0; bd_idx = 10'h0; bd_data = 32'h0;
        ref_clear();

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset done", {31'b0, done}, 32'h0);
        chk("reset err", {31'b0, err}, 32'h0);
        chk("reset mem_we", {31'b0, mem_we}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset state", {30'b0, dbg_state}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            t = $sformatf("vec%0d", i);
            if (vecs[i].pre) backdoor(4, vecs[i].pre_data);
            do_op(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 1'b0,
                  a_rd, a_err, a_lat, a_wes, a_wd, ab, bb, ib);
            chk({t, " latency"}, a_lat, vecs[i].exp_lat);
            chk({t, " err"}, {31'b0, a_err}, {31'b0, vecs[i].exp_err});
            chk({t, " rdata"}, a_rd, vecs[i].exp_rdata);
            chk({t, " mem_we pulses"}, a_wes, vecs[i].exp_wes);
            chk({t, " protocol"}, {29'b0, ab, bb, ib}, 32'h0);
            chk({t, " mem word"}, tb_mem[vecs[i].chk_idx], vecs[i].exp_word);
            if (vecs[i].exp_wes == 1) chk({t, " mem_wdata"}, a_wd, vecs[i].exp_word);
            ref_mem[vecs[i].chk_idx] = tb_mem[vecs[i].chk_idx];
        end
        // Keep the model aligned with whatever the table left behind.
        for (int i = 0; i < 1024; i++) ref_mem[i] = tb_mem[i];

        // ---- back-to-back with req held high ----
        backdoor(8, 32'h01020304);
        backdoor(9, 32'h05060708);
        run_checked("b2b0", 1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h000000A5, 1'b1);
        run_checked("b2b1", 1'b1, 2'd1, 1'b0, 32'h0000_0026, 32'h00001234, 1'b1);
        run_checked("b2b2", 1'b1, 2'd2, 1'b0, 32'h0000_0028, 32'hFEEDF00D, 1'b0);
        chk("b2b word8", tb_mem[8], 32'h0102A504);
        chk("b2b word9", tb_mem[9], 32'h12340708);
        chk("b2b word10", tb_mem[10], 32'hFEEDF00D);

        // ---- reset during RD of a sub-word store ----
        backdoor(5, 32'h55667788);
        req = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0000_0015; req_wdata = 32'h000000CC;
        @(posedge clk);
        @(negedge clk);
        chk("abort in RD", {30'b0, dbg_state}, 32'h1);
        req = 1'b0;
        rst = 1'b0;
        chk("abort mem_we on reset cycle", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        chk("abort busy", {31'b0, busy}, 32'h0);
        chk("abort done", {31'b0, done}, 32'h0);
        chk("abort err", {31'b0, err}, 32'h0);
        chk("abort mem_we", {31'b0, mem_we}, 32'h0);
        chk("abort rdata", rdata, 32'h0);
        chk("abort mem_addr", mem_addr, 32'h0);
        chk("abort mem_wdata", mem_wdata, 32'h0);
        chk("abort state", {30'b0, dbg_state}, 32'h0);
        rst = 1'b1;
        ref_clear();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post-abort idle", {30'b0, busy, mem_we}, 32'h0);
        end
        chk("post-abort word5", tb_mem[5], 32'h0);

        // ---- randomized regression ----
        for (int k = 0; k < 2000; k++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            int          r;
            r  = $urandom_range(0, 99);
            sz = (r < 8) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = 32'($urandom_range(0, 63)) * 4;
            if (sz == 2'd0) ad = ad + 32'($urandom_range(0, 3));
            else if (sz == 2'd1) ad = ad + 32'($urandom_range(0, 1)) * 2;
            r = $urandom_range(0, 99);
            if (r < 10) ad = {ad[31:2], 2'($urandom_range(0, 3))};
            else if (r < 14) ad = 32'h1000 + 32'($urandom);
            else if (r < 16) ad = 32'h0000_0FFC + 32'($urandom_range(0, 3));
            run_checked($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), sz,
                        1'($urandom_range(0, 1)), ad, 32'($urandom), 1'b0);
        end

        begin
            int diff;
            diff = 0;
            for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
            chk("final memory mismatching words", diff, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
